// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF butterfly stage: mode select, twiddle address, output valid and drain.
// Optional SDF_CTRL_FRAME_CNT_EN adds a frame counter and a DRAIN overrun pulse.
module sdf_stage_ctrl #(
    parameter int LOG2_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [1:0]            state,
    output logic [LOG2_DELAY-1:0] tw_addr,
    output logic                  out_valid,
    output logic                  frame_done,
    output logic                  err
`ifdef SDF_CTRL_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_cnt,
    output logic                  overrun
`endif
);

    // Encoding doubles as the datapath mode value driven on state.
    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_LOAD  = 2'd1,
        S_BFLY  = 2'd2,
        S_DRAIN = 2'd3
    } fsm_t;

    fsm_t                  r_fsm, w_fsm_nxt;
    logic [LOG2_DELAY:0]   r_cnt, w_cnt_nxt;
    logic [LOG2_DELAY-1:0] w_idx;
    logic                  w_idx_last, w_acc, w_adv, w_done_nxt, w_err_set;
    logic                  r_out_valid, r_frame_done, r_err;

    assign in_ready   = (r_fsm != S_DRAIN);
    assign w_acc      = in_valid & in_ready;
    assign w_adv      = w_acc | (r_fsm == S_DRAIN);
    assign w_idx      = r_cnt[LOG2_DELAY-1:0];
    assign w_idx_last = &w_idx;
    assign w_err_set  = w_acc & in_last & ~((r_fsm == S_BFLY) & w_idx_last);

    always_comb begin
        w_fsm_nxt  = r_fsm;
        w_cnt_nxt  = w_adv ? r_cnt + 1'b1 : r_cnt;
        w_done_nxt = 1'b0;
        case (r_fsm)
            S_FILL:  if (w_adv && w_idx_last) w_fsm_nxt = S_BFLY;
            S_LOAD:  if (w_adv && w_idx_last) w_fsm_nxt = S_BFLY;
            S_BFLY:  if (w_adv && w_idx_last) w_fsm_nxt = in_last ? S_DRAIN : S_LOAD;
            S_DRAIN: begin
                // Drain runs on cnt 0..DELAY-1; clearing here re-aligns FILL to block start.
                if (w_idx_last) begin
                    w_fsm_nxt  = S_FILL;
                    w_cnt_nxt  = '0;
                    w_done_nxt = 1'b1;
                end
            end
            default: w_fsm_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm        <= S_FILL;
            r_cnt        <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_fsm        <= w_fsm_nxt;
            r_cnt        <= w_cnt_nxt;
            r_out_valid  <= w_adv & (r_fsm != S_FILL);
            r_frame_done <= w_done_nxt;
            r_err        <= r_err | w_err_set;
        end
    end

    assign state      = r_fsm;
    assign tw_addr    = (r_fsm == S_BFLY) ? w_idx : '0;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;
    assign err        = r_err;

`ifdef SDF_CTRL_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_frame_cnt <= '0;
        else if (w_done_nxt) r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign frame_cnt = r_frame_cnt;
    assign overrun   = in_valid & (r_fsm == S_DRAIN);
`endif

endmodule
